// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter
//   Shares the single buzzer tone generator between three requesters using
//   fixed priority (req[2] alarm > req[1] key-click > req[0] music). An owner
//   keeps the buzzer for at least MIN_HOLD cycles before a higher requester
//   can preempt it. Every release or preemption is followed by GAP_CYC
//   cycles of enforced silence before the next grant.
//
//   Optional feature, macro BUZZ_ARB_TIMEOUT_EN:
//     A grant lasting MAX_HOLD cycles is forcibly ended (preempt pulses).
//     The timed-out requester is then locked out of arbitration until its
//     req drops for at least one cycle.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   req[2:0] in   level requests, bit 2 highest priority
//   gnt[2:0] out  registered one-hot grant, 0 when no owner
//   beep_en  out  tone generator enable, equals |gnt
//   owner    out  index of the current owner, 2'd3 when none
//   preempt  out  one-cycle pulse when an owner loses the grant involuntarily
//   busy     out  high while a grant or a silent gap is in progress
module buzzer_arbiter #(
    parameter int unsigned CLK_PRE  = 50_000_000,
    parameter int unsigned MIN_HOLD = 2_500_000,
    parameter int unsigned GAP_CYC  = 500_000,
    parameter int unsigned MAX_HOLD = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic       beep_en,
    output logic [1:0] owner,
    output logic       preempt,
    output logic       busy
);

    if (CLK_PRE == 0) begin : g_bad_clk
        $error("buzzer_arbiter: CLK_PRE must be non-zero");
    end
    if (MIN_HOLD < 1) begin : g_bad_hold
        $error("buzzer_arbiter: MIN_HOLD must be >= 1");
    end
    if (GAP_CYC < 1) begin : g_bad_gap
        $error("buzzer_arbiter: GAP_CYC must be >= 1");
    end
    if (MAX_HOLD <= MIN_HOLD) begin : g_bad_max
        $error("buzzer_arbiter: MAX_HOLD must exceed MIN_HOLD");
    end

    localparam int unsigned   HW       = $clog2(MIN_HOLD + 1);
    localparam int unsigned   GW       = $clog2(GAP_CYC + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);
    localparam logic [HW-1:0] HOLD_THR = HW'(MIN_HOLD - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [2:0] top_req(input logic [2:0] r);
        logic [2:0] oh;
        oh = 3'b000;
        if (r[2])      oh = 3'b100;
        else if (r[1]) oh = 3'b010;
        else if (r[0]) oh = 3'b001;
        return oh;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b100:  idx = 2'd2;
            3'b010:  idx = 2'd1;
            3'b001:  idx = 2'd0;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [2:0]    gnt_d;
    logic [1:0]    owner_d;
    logic          preempt_d;

    logic [2:0]    elig;        // requests allowed to compete this cycle
    logic [2:0]    grant_oh;    // winner among elig
    logic [2:0]    higher;      // eligible requests above the current owner
    logic          own_req;
    logic          preempt_hit;
    logic          start_grant;

`ifdef BUZZ_ARB_TIMEOUT_EN
    localparam int unsigned   TW       = $clog2(MAX_HOLD + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(MAX_HOLD - 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic [2:0]    lock_q, lock_d;
    logic          timeout_hit;

    assign elig        = req & ~lock_q;
    assign timeout_hit = (tmo_q == TMO_LAST);
    assign preempt_hit = ((|higher) && (hold_q >= HOLD_THR)) || timeout_hit;
`else
    assign elig        = req;
    assign preempt_hit = (|higher) && (hold_q >= HOLD_THR);
`endif

    assign grant_oh = top_req(elig);
    assign own_req  = |(req & gnt);

    always_comb begin
        case (owner)
            2'd0:    higher = elig & 3'b110;
            2'd1:    higher = elig & 3'b100;
            default: higher = 3'b000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt;
        owner_d     = owner;
        preempt_d   = 1'b0;
        hold_d      = hold_q;
        gap_d       = gap_q;
        start_grant = 1'b0;
`ifdef BUZZ_ARB_TIMEOUT_EN
        tmo_d       = tmo_q;
        lock_d      = lock_q & req;   // a dropped request clears its lockout
`endif
        case (state_q)
            IDLE: begin
                start_grant = |elig;
            end
            GRANT: begin
                hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
`ifdef BUZZ_ARB_TIMEOUT_EN
                tmo_d  = tmo_q + 1'b1;
`endif
                if (!own_req || preempt_hit) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    owner_d   = 2'd3;
                    gap_d     = '0;
                    // A coincident release wins: no preempt pulse then.
                    preempt_d = own_req;
`ifdef BUZZ_ARB_TIMEOUT_EN
                    if (own_req && timeout_hit) begin
                        lock_d = lock_d | gnt;
                    end
`endif
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    start_grant = |elig;
                    if (!(|elig)) begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                owner_d = 2'd3;
            end
        endcase

        if (start_grant) begin
            state_d = GRANT;
            gnt_d   = grant_oh;
            owner_d = onehot_idx(grant_oh);
            hold_d  = '0;
`ifdef BUZZ_ARB_TIMEOUT_EN
            tmo_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt     <= '0;
            beep_en <= 1'b0;
            owner   <= 2'd3;
            preempt <= 1'b0;
            busy    <= 1'b0;
            hold_q  <= '0;
            gap_q   <= '0;
`ifdef BUZZ_ARB_TIMEOUT_EN
            tmo_q   <= '0;
            lock_q  <= '0;
`endif
        end else begin
            gnt     <= gnt_d;
            beep_en <= |gnt_d;
            owner   <= owner_d;
            preempt <= preempt_d;
            busy    <= (state_d != IDLE);
            hold_q  <= hold_d;
            gap_q   <= gap_d;
`ifdef BUZZ_ARB_TIMEOUT_EN
            tmo_q   <= tmo_d;
            lock_q  <= lock_d;
`endif
        end
    end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// tb_buzzer_arbiter
//   Drives buzzer_arbiter with a table of directed request patterns, a
//   mid-grant asynchronous reset and randomized request toggling, and checks
//   all outputs every cycle against a cycle-level behavioural model.
module tb_buzzer_arbiter;

    localparam int unsigned MIN_HOLD = 8;
    localparam int unsigned GAP_CYC  = 4;
    localparam int unsigned MAX_HOLD = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] gnt;
    logic       beep_en;
    logic [1:0] owner;
    logic       preempt;
    logic       busy;

    always #5 clk = ~clk;

    buzzer_arbiter #(
        .CLK_PRE (50_000_000),
        .MIN_HOLD(MIN_HOLD),
        .GAP_CYC (GAP_CYC),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .gnt    (gnt),
        .beep_en(beep_en),
        .owner  (owner),
        .preempt(preempt),
        .busy   (busy)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model: who owns the buzzer, for how many cycles, and how much
    // silence is still owed before the next grant.
    int         m_owner;      // -1 when nobody holds the buzzer
    int         m_held;       // cycles the current owner has held it
    int         m_gap_left;   // silent cycles still to run
    logic [2:0] m_lock;
    logic       m_pre;

    typedef struct {
        logic [2:0]  r;
        int unsigned n;
    } seg_t;

    localparam int NSEG = 25;
    seg_t segs [NSEG] = '{
        '{3'b000, 6},  '{3'b001, 20}, '{3'b000, 8},  '{3'b111, 12},
        '{3'b011, 12}, '{3'b000, 10}, '{3'b001, 3},  '{3'b101, 16},
        '{3'b000, 8},  '{3'b010, 1},  '{3'b110, 7},  '{3'b100, 8},
        '{3'b000, 8},  '{3'b001, 45}, '{3'b000, 1},  '{3'b001, 12},
        '{3'b000, 8},  '{3'b010, 3},  '{3'b000, 1},  '{3'b100, 1},
        '{3'b000, 8},  '{3'b010, 3},  '{3'b000, 4},  '{3'b100, 6},
        '{3'b000, 8}
    };

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner    = -1;
        m_held     = 0;
        m_gap_left = 0;
        m_lock     = 3'b000;
        m_pre      = 1'b0;
    endtask

    task automatic model_grant(input logic [2:0] elig);
        for (int b = 2; b >= 0; b--) begin
            if (elig[b] && m_owner < 0) begin
                m_owner = b;
                m_held  = 0;
            end
        end
    endtask

    // Advance the model by one clock edge with request vector r.
    task automatic model_step(input logic [2:0] r);
        logic [2:0] elig;
        logic [2:0] set_lock;
        logic       higher;
        logic       timeout;
        elig     = r & ~m_lock;
        set_lock = 3'b000;
        m_pre    = 1'b0;
        if (m_owner >= 0) begin
            m_held++;
            higher = 1'b0;
            for (int b = m_owner + 1; b < 3; b++) begin
                if (elig[b]) higher = 1'b1;
            end
            timeout = 1'b0;
`ifdef BUZZ_ARB_TIMEOUT_EN
            timeout = (m_held >= MAX_HOLD);
`endif
            if (!r[m_owner]) begin
                m_owner    = -1;
                m_gap_left = GAP_CYC;
            end else if ((higher && m_held >= MIN_HOLD) || timeout) begin
                if (timeout) set_lock[m_owner] = 1'b1;
                m_pre      = 1'b1;
                m_owner    = -1;
                m_gap_left = GAP_CYC;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
            if (m_gap_left == 0) model_grant(elig);
        end else begin
            model_grant(elig);
        end
`ifdef BUZZ_ARB_TIMEOUT_EN
        m_lock = (m_lock & r) | set_lock;
`endif
    endtask

    task automatic compare_outputs();
        logic [2:0] e_gnt;
        logic [1:0] e_owner;
        e_gnt   = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        e_owner = (m_owner >= 0) ? 2'(m_owner) : 2'd3;
        check("gnt",     8'(gnt),     8'(e_gnt));
        check("beep_en", 8'(beep_en), 8'(m_owner >= 0));
        check("owner",   8'(owner),   8'(e_owner));
        check("preempt", 8'(preempt), 8'(m_pre));
        check("busy",    8'(busy),    8'((m_owner >= 0) || (m_gap_left > 0)));
    endtask

    // Called at a falling edge: check what the last rising edge produced,
    // then present the next request vector.
    task automatic step_cycle(input logic [2:0] r);
        compare_outputs();
        req = r;
        model_step(r);
        @(negedge clk);
    endtask

    task automatic run_random(input int unsigned cycles, input int unsigned p);
        logic [2:0] cur;
        cur = req;
        for (int unsigned i = 0; i < cycles; i++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(p - 1, 0) == 0) cur[b] = ~cur[b];
            end
            step_cycle(cur);
        end
    endtask

    task automatic reset_mid();
        #2 rst_n = 1'b0;
        #1;
        check("rst_gnt",     8'(gnt),     8'd0);
        check("rst_beep_en", 8'(beep_en), 8'd0);
        check("rst_busy",    8'(busy),    8'd0);
        check("rst_owner",   8'(owner),   8'd3);
        check("rst_preempt", 8'(preempt), 8'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        req   = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < NSEG; s++) begin
            for (int unsigned i = 0; i < segs[s].n; i++) begin
                step_cycle(segs[s].r);
            end
        end

        for (int unsigned i = 0; i < 5; i++) step_cycle(3'b010);
        check("pre_rst_owner", 8'(owner), 8'd1);
        reset_mid();
        for (int unsigned i = 0; i < 4; i++) step_cycle(3'b010);
        for (int unsigned i = 0; i < 8; i++) step_cycle(3'b000);

        run_random(1500, 12);
        run_random(1500, 30);
        run_random(800, 4);

        compare_outputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
